// File: rtl/swipt_frame_receiver.sv
// Framed serial receiver for the SWIPT data link: start bit, payload MSB first, ones-count checksum.
// Define SWIPT_RX_GLITCH_FILTER_EN to insert a 3-sample majority filter on the synchronised line.
module swipt_frame_receiver #(
    parameter int unsigned BIT_PERIOD   = 200000,
    parameter int unsigned PAYLOAD_BITS = 28,
    parameter int unsigned CHK_BITS     = 8
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic                    swipt_alive,
    input  logic                    rx_en,
    input  logic                    din,
    output logic [PAYLOAD_BITS-1:0] frame_data,
    output logic                    frame_valid,
    input  logic                    frame_ready,
    output logic                    chk_ok,
    output logic                    overrun,
    output logic                    busy
);
    localparam int unsigned FRAME_BITS = PAYLOAD_BITS + CHK_BITS;
    localparam int unsigned CNT_W      = $clog2(BIT_PERIOD);
    localparam int unsigned BITS_W     = $clog2(FRAME_BITS + 1);

    localparam logic [CNT_W-1:0]  HALF_RELOAD = CNT_W'(BIT_PERIOD / 2 - 1);
    localparam logic [CNT_W-1:0]  FULL_RELOAD = CNT_W'(BIT_PERIOD - 1);
    localparam logic [BITS_W-1:0] LAST_BIT    = BITS_W'(FRAME_BITS - 1);
    localparam logic [BITS_W-1:0] PAY_BITS    = BITS_W'(PAYLOAD_BITS);

    typedef enum logic [1:0] {StIdle, StStart, StData, StDone} state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q;
    logic [BITS_W-1:0]       bit_cnt_q;
    logic [FRAME_BITS-1:0]   shift_q;
    logic [CHK_BITS-1:0]     ones_q;

    logic din_meta_q, din_sync_q;
    logic din_f;
    logic din_prev_q;
    logic rise;
    logic primed;
    logic abort;
    logic cnt_zero;
    logic last_bit;
    logic in_done;

    // Two-flop synchroniser for the asynchronous line.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            din_meta_q <= 1'b0;
            din_sync_q <= 1'b0;
        end else begin
            din_meta_q <= din;
            din_sync_q <= din_meta_q;
        end
    end

`ifdef SWIPT_RX_GLITCH_FILTER_EN
    localparam int unsigned PIPE_DEPTH = 5;

    logic [2:0] flt_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            flt_q <= '0;
        end else begin
            flt_q <= {flt_q[1:0], din_sync_q};
        end
    end

    assign din_f = (flt_q[0] & flt_q[1]) | (flt_q[0] & flt_q[2]) | (flt_q[1] & flt_q[2]);
`else
    localparam int unsigned PIPE_DEPTH = 2;

    assign din_f = din_sync_q;
`endif

    // Tracks when the input pipeline holds real samples rather than reset zeros, so a line
    // already high at reset release is not mistaken for a start edge.
    logic [PIPE_DEPTH-1:0] pipe_vld_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            pipe_vld_q <= '0;
        end else begin
            pipe_vld_q <= {pipe_vld_q[PIPE_DEPTH-2:0], 1'b1};
        end
    end

    assign primed = pipe_vld_q[PIPE_DEPTH-1];

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            din_prev_q <= 1'b1;
        end else if (primed) begin
            din_prev_q <= din_f;
        end
    end

    assign rise     = primed & din_f & ~din_prev_q;
    assign abort    = ~swipt_alive | ~rx_en;
    assign cnt_zero = (cnt_q == '0);
    assign last_bit = (bit_cnt_q == LAST_BIT);

    // FSM: state register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state.
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:  if (rise) state_d = StStart;
                StStart: if (cnt_zero) state_d = din_f ? StData : StIdle;
                StData:  if (cnt_zero && last_bit) state_d = StDone;
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    // FSM: outputs.
    always_comb begin
        busy    = (state_q != StIdle);
        in_done = (state_q == StDone);
    end

    // Bit timing, shift register and payload ones-count.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            ones_q    <= '0;
        end else if (abort) begin
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            ones_q    <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (rise) cnt_q <= HALF_RELOAD;
                end
                StStart: begin
                    if (cnt_zero) begin
                        cnt_q     <= din_f ? FULL_RELOAD : '0;
                        bit_cnt_q <= '0;
                        shift_q   <= '0;
                        ones_q    <= '0;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                StData: begin
                    if (cnt_zero) begin
                        shift_q   <= {shift_q[FRAME_BITS-2:0], din_f};
                        bit_cnt_q <= bit_cnt_q + BITS_W'(1);
                        cnt_q     <= FULL_RELOAD;
                        if (bit_cnt_q < PAY_BITS) ones_q <= ones_q + CHK_BITS'(din_f);
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Output handshake; a completed frame may replace one being accepted in the same cycle.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            frame_data  <= '0;
            frame_valid <= 1'b0;
            chk_ok      <= 1'b0;
            overrun     <= 1'b0;
        end else if (abort) begin
            frame_valid <= 1'b0;
            chk_ok      <= 1'b0;
            overrun     <= 1'b0;
        end else if (in_done) begin
            if (!frame_valid || frame_ready) begin
                frame_data  <= shift_q[FRAME_BITS-1:CHK_BITS];
                chk_ok      <= (ones_q == shift_q[CHK_BITS-1:0]);
                frame_valid <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end else if (frame_valid && frame_ready) begin
            frame_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_swipt_frame_receiver.sv
// Bench for swipt_frame_receiver: frames driven on din, expected payload/checksum verdicts
// queued at send time and compared whenever the DUT hands a frame over.
module tb_swipt_frame_receiver;
    localparam int unsigned BP = 8;
    localparam int unsigned PB = 8;
    localparam int unsigned CB = 4;

    logic          clk = 1'b0;
    logic          nrst;
    logic          swipt_alive;
    logic          rx_en;
    logic          din;
    logic          frame_ready;
    logic [PB-1:0] frame_data;
    logic          frame_valid;
    logic          chk_ok;
    logic          overrun;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [PB:0] exp_q[$];  // {chk_ok, payload}

    logic saw_busy;
    logic saw_valid;

    always #5 clk = ~clk;

    swipt_frame_receiver #(
        .BIT_PERIOD  (BP),
        .PAYLOAD_BITS(PB),
        .CHK_BITS    (CB)
    ) dut (
        .clk        (clk),
        .nrst       (nrst),
        .swipt_alive(swipt_alive),
        .rx_en      (rx_en),
        .din        (din),
        .frame_data (frame_data),
        .frame_valid(frame_valid),
        .frame_ready(frame_ready),
        .chk_ok     (chk_ok),
        .overrun    (overrun),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        din = 1'b0;
        repeat (n) tick();
    endtask

    // Start bit followed by the top nbits of a 12-bit frame; din is left at the last bit.
    task automatic send_bits(input logic [11:0] bits, input int nbits);
        din = 1'b1;
        repeat (BP) tick();
        for (int i = 0; i < nbits; i++) begin
            din = bits[11-i];
            repeat (BP) tick();
        end
    endtask

    task automatic send_frame(input logic [PB-1:0] payload, input logic [CB-1:0] chk,
                              input bit push);
        logic [CB-1:0] ones;
        ones = CB'($countones(payload));
        if (push) exp_q.push_back({(ones == chk), payload});
        send_bits({payload, chk}, PB + CB);
    endtask

    task automatic wait_valid(input string tag);
        int i = 0;
        while (!frame_valid && i < 40) begin
            tick();
            i++;
        end
        check(tag, 64'(frame_valid), 64'd1);
    endtask

    // Scoreboard: every hand-over must match the oldest queued expectation.
    always @(negedge clk) begin
        if (nrst && frame_valid && frame_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_pending", 64'(exp_q.size()), 64'd1);
            end else begin
                logic [PB:0] e;
                e = exp_q.pop_front();
                check("sb_data", 64'(frame_data), 64'(e[PB-1:0]));
                check("sb_chk_ok", 64'(chk_ok), 64'(e[PB]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        nrst        = 1'b0;
        swipt_alive = 1'b1;
        rx_en       = 1'b1;
        din         = 1'b0;
        frame_ready = 1'b1;
        repeat (3) tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_valid", 64'(frame_valid), 64'd0);
        check("rst_data", 64'(frame_data), 64'd0);
        check("rst_chk_ok", 64'(chk_ok), 64'd0);
        check("rst_overrun", 64'(overrun), 64'd0);
        nrst = 1'b1;
        idle(4);

        // Good frame, consumer ready: one-cycle valid.
        send_frame(8'hA5, 4'h4, 1'b1);
        din = 1'b0;
        wait_valid("a5_valid");
        check("a5_data", 64'(frame_data), 64'hA5);
        check("a5_chk_ok", 64'(chk_ok), 64'd1);
        tick();
        check("a5_one_cycle", 64'(frame_valid), 64'd0);
        idle(4);

        // Bad checksum still presented; din then held high must not restart.
        send_frame(8'hA5, 4'h3, 1'b1);
        wait_valid("bad_valid");
        check("bad_chk_ok", 64'(chk_ok), 64'd0);
        check("bad_overrun", 64'(overrun), 64'd0);
        saw_busy = 1'b0;
        repeat (30) begin
            tick();
            if (busy) saw_busy = 1'b1;
        end
        check("hold_high_no_start", 64'(saw_busy), 64'd0);
        idle(4);

        // Link power loss drops a pending frame but keeps its data.
        frame_ready = 1'b0;
        send_frame(8'h5A, 4'h4, 1'b0);
        din = 1'b0;
        wait_valid("alive_valid");
        check("alive_chk_before", 64'(chk_ok), 64'd1);
        swipt_alive = 1'b0;
        tick();
        check("alive_valid_clr", 64'(frame_valid), 64'd0);
        check("alive_chk_clr", 64'(chk_ok), 64'd0);
        check("alive_data_kept", 64'(frame_data), 64'h5A);
        swipt_alive = 1'b1;
        frame_ready = 1'b1;
        idle(4);

        // Short pulse is a false start.
        din = 1'b1;
        repeat (2) tick();
        din = 1'b0;
        saw_busy  = 1'b0;
        saw_valid = 1'b0;
        repeat (20) begin
            tick();
            if (busy) saw_busy = 1'b1;
            if (frame_valid) saw_valid = 1'b1;
        end
`ifndef SWIPT_RX_GLITCH_FILTER_EN
        check("glitch_started", 64'(saw_busy), 64'd1);
`endif
        check("glitch_no_valid", 64'(saw_valid), 64'd0);
        check("glitch_idle", 64'(busy), 64'd0);
        check("glitch_data_kept", 64'(frame_data), 64'h5A);

        // Overrun: second frame while first is unaccepted.
        frame_ready = 1'b0;
        send_frame(8'h11, 4'h2, 1'b1);
        din = 1'b0;
        wait_valid("ovr_first_valid");
        check("ovr_first_data", 64'(frame_data), 64'h11);
        check("ovr_first_flag", 64'(overrun), 64'd0);
        idle(4);
        send_frame(8'h22, 4'h2, 1'b0);
        idle(6);
        check("ovr_flag", 64'(overrun), 64'd1);
        check("ovr_data_kept", 64'(frame_data), 64'h11);
        check("ovr_still_valid", 64'(frame_valid), 64'd1);
        frame_ready = 1'b1;
        tick();
        frame_ready = 1'b0;
        check("ovr_accept_clr", 64'(frame_valid), 64'd0);
        check("ovr_sticky", 64'(overrun), 64'd1);
        idle(4);

        // rx_en abort mid-frame, then a clean frame.
        send_bits({8'h3C, 4'h4}, 5);
        check("abort_busy_before", 64'(busy), 64'd1);
        rx_en = 1'b0;
        tick();
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_overrun", 64'(overrun), 64'd0);
        check("abort_valid", 64'(frame_valid), 64'd0);
        check("abort_data_kept", 64'(frame_data), 64'h11);
        rx_en       = 1'b1;
        frame_ready = 1'b1;
        idle(4);
        send_frame(8'h3C, 4'h4, 1'b1);
        din = 1'b0;
        wait_valid("3c_valid");
        check("3c_data", 64'(frame_data), 64'h3C);
        tick();
        idle(4);

        // Asynchronous reset mid-frame with din high.
        send_bits({8'hE0, 4'h3}, 3);
        check("nrst_busy_before", 64'(busy), 64'd1);
        nrst = 1'b0;
        #1;
        check("nrst_busy", 64'(busy), 64'd0);
        check("nrst_data", 64'(frame_data), 64'd0);
        check("nrst_valid", 64'(frame_valid), 64'd0);
        check("nrst_chk_ok", 64'(chk_ok), 64'd0);
        check("nrst_overrun", 64'(overrun), 64'd0);
        tick();
        nrst = 1'b1;
        saw_busy = 1'b0;
        repeat (40) begin
            tick();
            if (busy) saw_busy = 1'b1;
        end
        check("nrst_no_start", 64'(saw_busy), 64'd0);
        idle(4);
        send_frame(8'h5A, 4'h4, 1'b1);
        din = 1'b0;
        wait_valid("post_rst_valid");
        tick();
        idle(4);

        check("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
